serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing `a - b` one bit per clock, LSB first. It is the sequential counterpart to the team's ripple-carry adder datapath: the same gate-level cell style, but with the difference formed by a single `full_subtractor` cell. Borrow is carried in a flip-flop between cycles. It serves area-constrained datapaths where WIDTH cycles of latency are acceptable, and uses a start/done handshake toward the controlling FSM.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock, the only clock.
- `rst`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  WIDTH  minuend; sampled in the cycle `start` is accepted.
- `b`  input  WIDTH  subtrahend; sampled with `a`.
- `busy`  output  1  high while an operation is in progress (states SHIFT and DONE).
- `done`  output  1  one-cycle pulse when the result is valid.
- `diff`  output  WIDTH  `(a - b) mod 2^WIDTH`; holds its value until the next completion.
- `borrow_out`  output  1  final borrow; 1 iff unsigned `a < b`.
- `ovf`  output  1  signed overflow: `a[MSB] != b[MSB]` and `diff[MSB] != a[MSB]`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - On `start=1`, latch `a` and `b` into shift registers `a_sr` and `b_sr`.
  - Clear the borrow flop and the bit counter `cnt`, then go to SHIFT.
  - On `start=0`, stay in IDLE.
- **SHIFT**, once per cycle:
  - The `full_subtractor` takes `a_sr[0]`, `b_sr[0]` and the borrow flop, and produces `d` and `bout`.
  - `d` shifts into the MSB of the internal register `d_sr`; `a_sr` and `b_sr` shift right.
  - The borrow flop loads `bout`, and `cnt` increments.
  - When `cnt == WIDTH-1` in the current cycle, the next state is DONE.
- **DONE**
  - Copy `d_sr` to `diff` and the borrow flop to `borrow_out`.
  - Compute `ovf` from the latched operand MSBs and `d_sr[MSB]`.
  - Assert `done` for exactly this cycle, then go to IDLE unconditionally.
- `start` is ignored in SHIFT and DONE; there is no queuing.
- `a` and `b` are don't-care outside the accept cycle.
- The output registers `diff`, `borrow_out` and `ovf` update only in DONE. An in-flight operation never disturbs them.
- `cnt` width is `$clog2(WIDTH)`. There is no wrap-around hazard because the SHIFT exit occurs at `WIDTH-1`.
- **Reset**, including mid-operation:
  - Next state is IDLE.
  - `busy=0`, `done=0`, `diff=0`, `borrow_out=0`, `ovf=0`.
  - The shift registers, `cnt` and the borrow flop are cleared.
  - A partially computed result is discarded and never reported.
- If `rst` and `start` are high in the same cycle, `rst` wins and `start` is dropped.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..WIDTH: SHIFT, bit `i` computed in cycle `i+1`.
- Cycle WIDTH+1: DONE, with `done=1` and new `diff`, `borrow_out`, `ovf` visible on the same cycle's registered outputs.
- Cycle WIDTH+2: IDLE, which is the earliest cycle a new `start` is accepted.
- Throughput is one operation per WIDTH+2 cycles.
- `busy` rises in cycle 1 and falls in cycle WIDTH+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `arith_pkg`:
  - State encoding constants `ST_IDLE=2'd0`, `ST_SHIFT=2'd1`, `ST_DONE=2'd2`.
  - `MAX_WIDTH=32`.
- One sub-module, `full_subtractor` (A, B, Bin, D, Bout), built from the existing `xor_gate2`, `and_gate` and `or_gate` cells.
  - `D = A^B^Bin`.
  - `Bout = (~A&B) | (~(A^B)&Bin)`.
  - The inverter is placed in-line.
- Top level holds the FSM, the three shift registers, the counter, the borrow flop and the output registers.

## Test plan
- WIDTH=8, `a=0x5A`, `b=0x23`, single `start` -> `done` in cycle 9, `diff=0x37`, `borrow_out=0`, `ovf=0`.
- `a=0x10`, `b=0x20` -> `diff=0xF0`, `borrow_out=1`, `ovf=0`. Then `a=0x80`, `b=0x01` -> `diff=0x7F`, `borrow_out=0`, `ovf=1`.
- Pulse `start` with `a=0x00`, `b=0x01`; in cycle 3 pulse `start` again with `a=0xFF`, `b=0x00` -> exactly one `done`, `diff=0xFF`, `borrow_out=1`; the second request is ignored.
- Complete `0x30-0x10` (`diff=0x20`), then start `0x05-0x03` and assert `rst` in cycle 4:
  - From the next cycle, all outputs are 0 and `busy=0`.
  - No `done` follows.
  - A subsequent `0x05-0x03` yields `diff=0x02` at the correct latency.
- Back-to-back operations with `start` held high continuously -> accepts occur every 10 cycles and each `done` is one cycle wide.
- Random sweep of 1000 operand pairs at WIDTH=8 and WIDTH=2 against a reference model computing `a-b`, the borrow and signed overflow.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arith_pkg
// Purpose : Shared arithmetic-datapath constants. Holds the state encoding for
//           the bit-serial subtractor controller and the widest legal operand.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package arith_pkg;

    // Controller state encoding (explicit 2-bit width)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Widest operand the serial datapath is qualified for
    localparam int MAX_WIDTH = 32;

endpackage : arith_pkg
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_subtractor_if
// Purpose : Start/done handshake and operand/result bundle between a
//           controlling FSM (master) and the serial subtractor (slave).
// Ports   : start, a, b            master -> slave
//           busy, done, diff,
//           borrow_out, ovf        slave  -> master
// Revision: 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, ovf
    );
endinterface : serial_subtractor_if
`default_nettype wire

// File: rtl/serial_subtractor_fs.sv
`default_nettype none
// ============================================================================
// Module  : full_subtractor (plus xor_gate2 / and_gate / or_gate cells)
// Purpose : One-bit full subtractor built from the two-input gate cells of
//           the ripple-carry datapath library.
//             D    = A ^ B ^ Bin
//             Bout = (~A & B) | (~(A ^ B) & Bin)
// Ports   : A, B, Bin  in   minuend bit, subtrahend bit, borrow in
//           D, Bout    out  difference bit, borrow out
// Revision: 1.0 - initial release
// ============================================================================
module xor_gate2 (
    input  wire logic a,
    input  wire logic b,
    output wire logic y
);
    assign y = a ^ b;
endmodule : xor_gate2

module and_gate (
    input  wire logic a,
    input  wire logic b,
    output wire logic y
);
    assign y = a & b;
endmodule : and_gate

module or_gate (
    input  wire logic a,
    input  wire logic b,
    output wire logic y
);
    assign y = a | b;
endmodule : or_gate

module full_subtractor (
    input  wire logic A,
    input  wire logic B,
    input  wire logic Bin,
    output wire logic D,
    output wire logic Bout
);
    logic w_axb;
    logic w_gen;    // borrow generated here: A=0, B=1
    logic w_prop;   // borrow propagated: A==B and a borrow came in

    xor_gate2 u_xor_ab  (.a(A),      .b(B),   .y(w_axb));
    xor_gate2 u_xor_d   (.a(w_axb),  .b(Bin), .y(D));
    and_gate  u_and_gen (.a(~A),     .b(B),   .y(w_gen));
    and_gate  u_and_prp (.a(~w_axb), .b(Bin), .y(w_prop));
    or_gate   u_or_bout (.a(w_gen),  .b(w_prop), .y(Bout));
endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : serial_subtractor
// Purpose : Bit-serial a - b, LSB first, one bit per clock through a single
//           full_subtractor cell; borrow is held in a flop between cycles.
//           Latency WIDTH+1 cycles from accept to done, one operation per
//           WIDTH+2 cycles. All outputs registered.
// Ports   : clk         in   rising-edge clock
//           rst         in   synchronous active-high reset
//           bus         slave modport of serial_subtractor_if
//                       (start/a/b in; busy/done/diff/borrow_out/ovf out)
// Params  : WIDTH       operand width, legal range 2..MAX_WIDTH
// Revision: 1.0 - initial release
// ============================================================================
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_subtractor_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    // Only WIDTH-1 result bits need storing: the last bit comes straight from
    // the cell in the final SHIFT cycle.
    logic [WIDTH-2:0] r_d_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_ovf;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_shift;

    full_subtractor u_fs (
        .A    (r_a_sr[0]),
        .B    (r_b_sr[0]),
        .Bin  (r_borrow),
        .D    (w_d),
        .Bout (w_bout)
    );

    // Result register with the current bit shifted in at the MSB
    assign w_shift = {w_d, r_d_sr};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_d_sr       <= '0;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a_sr   <= bus.a;
                        r_b_sr   <= bus.b;
                        r_a_msb  <= bus.a[WIDTH-1];
                        r_b_msb  <= bus.b[WIDTH-1];
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_d_sr   <= w_shift[WIDTH-1:1];
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        // Results are loaded on the edge entering DONE so they
                        // are already valid during the done pulse.
                        r_state      <= ST_DONE;
                        r_done       <= 1'b1;
                        r_diff       <= w_shift;
                        r_borrow_out <= w_bout;
                        r_ovf        <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;
    assign bus.ovf        = r_ovf;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_subtractor
// Purpose : Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=2.
//           Directed handshake/reset scenarios plus a random operand sweep
//           against an arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(2)) bus2 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain modular arithmetic on the operand values
    task automatic ref_sub(input int w, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] d, output logic bo, output logic ov);
        logic [32:0] mask;
        mask = (33'd1 << w) - 33'd1;
        d    = (a - b) & mask[31:0];
        bo   = (a < b);
        ov   = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [31:0] ed;
        logic        eb, eo;
        int          lat;
        ref_sub(8, {24'd0, a}, {24'd0, b}, ed, eb, eo);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b;
        tick();
        bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        check({tag, "_busy1"}, {31'd0, bus8.busy}, 32'd1);
        lat = 1;
        while (!bus8.done && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd9);
        check({tag, "_diff"}, {24'd0, bus8.diff}, ed);
        check({tag, "_borrow"}, {31'd0, bus8.borrow_out}, {31'd0, eb});
        check({tag, "_ovf"}, {31'd0, bus8.ovf}, {31'd0, eo});
        tick();
        check({tag, "_done_width"}, {31'd0, bus8.done}, 32'd0);
        check({tag, "_busy_fall"}, {31'd0, bus8.busy}, 32'd0);
    endtask

    task automatic run_op2(input logic [1:0] a, input logic [1:0] b);
        logic [31:0] ed;
        logic        eb, eo;
        int          lat;
        ref_sub(2, {30'd0, a}, {30'd0, b}, ed, eb, eo);
        bus2.start = 1'b1; bus2.a = a; bus2.b = b;
        tick();
        bus2.start = 1'b0; bus2.a = 2'($urandom); bus2.b = 2'($urandom);
        lat = 1;
        while (!bus2.done && lat < 20) begin
            tick();
            lat++;
        end
        check("w2_latency", lat, 32'd3);
        check("w2_diff", {30'd0, bus2.diff}, ed);
        check("w2_borrow", {31'd0, bus2.borrow_out}, {31'd0, eb});
        check("w2_ovf", {31'd0, bus2.ovf}, {31'd0, eo});
        tick();
        check("w2_done_width", {31'd0, bus2.done}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_done;
        logic [7:0]  cap_diff;
        logic        cap_borrow;

        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
        bus2.start = 1'b0; bus2.a = 2'h0;  bus2.b = 2'h0;
        repeat (3) tick();
        check("rst_busy", {31'd0, bus8.busy}, 32'd0);
        check("rst_done", {31'd0, bus8.done}, 32'd0);
        check("rst_diff", {24'd0, bus8.diff}, 32'd0);
        check("rst_borrow", {31'd0, bus8.borrow_out}, 32'd0);
        check("rst_ovf", {31'd0, bus8.ovf}, 32'd0);
        check("rst_w2_diff", {30'd0, bus2.diff}, 32'd0);
        rst = 1'b0;
        tick();

        // Directed operand cases
        run_op8(8'h5A, 8'h23, "d5a_23");
        check("d5a_23_diff_const", {24'd0, bus8.diff}, 32'h37);
        run_op8(8'h10, 8'h20, "d10_20");
        check("d10_20_borrow_const", {31'd0, bus8.borrow_out}, 32'd1);
        run_op8(8'h80, 8'h01, "d80_01");
        check("d80_01_ovf_const", {31'd0, bus8.ovf}, 32'd1);

        // Second start during SHIFT is ignored
        bus8.start = 1'b1; bus8.a = 8'h00; bus8.b = 8'h01;
        tick();
        bus8.start = 1'b0;
        tick(); tick();
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h00;
        tick();
        bus8.start = 1'b0;
        n_done = 0; cap_diff = 8'h00; cap_borrow = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (bus8.done) begin
                n_done++;
                cap_diff   = bus8.diff;
                cap_borrow = bus8.borrow_out;
            end
            tick();
        end
        check("ignore_done_count", n_done, 32'd1);
        check("ignore_diff", {24'd0, cap_diff}, 32'hFF);
        check("ignore_borrow", {31'd0, cap_borrow}, 32'd1);

        // Reset in the middle of an operation
        run_op8(8'h30, 8'h10, "d30_10");
        bus8.start = 1'b1; bus8.a = 8'h05; bus8.b = 8'h03;
        tick();
        bus8.start = 1'b0;
        tick(); tick();
        check("inflight_hold_diff", {24'd0, bus8.diff}, 32'h20);
        tick();                       // now in cycle 4
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {31'd0, bus8.busy}, 32'd0);
        check("midrst_done", {31'd0, bus8.done}, 32'd0);
        check("midrst_diff", {24'd0, bus8.diff}, 32'd0);
        check("midrst_borrow", {31'd0, bus8.borrow_out}, 32'd0);
        check("midrst_ovf", {31'd0, bus8.ovf}, 32'd0);
        n_done = 0;
        for (int t = 0; t < 15; t++) begin
            if (bus8.done || bus8.busy) n_done++;
            tick();
        end
        check("midrst_no_done", n_done, 32'd0);
        run_op8(8'h05, 8'h03, "after_rst");

        // Reset and start together: reset wins
        bus8.start = 1'b1; bus8.a = 8'h44; bus8.b = 8'h11; rst = 1'b1;
        tick();
        rst = 1'b0; bus8.start = 1'b0;
        tick();
        check("rst_start_busy", {31'd0, bus8.busy}, 32'd0);

        // Start held high: accept every 10 cycles, done in cycle 9 of each
        bus8.start = 1'b1; bus8.a = 8'h9C; bus8.b = 8'h3E;
        n_done = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (bus8.done) begin
                n_done++;
                check("b2b_phase", t % 10, 32'd9);
                check("b2b_diff", {24'd0, bus8.diff}, 32'h5E);
            end
            if (t % 10 == 1) check("b2b_busy", {31'd0, bus8.busy}, 32'd1);
        end
        bus8.start = 1'b0;
        check("b2b_count", n_done, 32'd4);
        tick(); tick();

        // Random sweeps
        for (int i = 0; i < 1000; i++) run_op8(8'($urandom), 8'($urandom), "rnd8");
        for (int i = 0; i < 1000; i++) run_op2(2'($urandom), 2'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire
